// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: parameter legality
// and small constant functions used at elaboration time.
package cla_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int unsigned width, input int unsigned stages,
                                   input int unsigned group);
    if (stages < 1 || stages > 8) return 1'b0;
    if (group < 1 || width < stages) return 1'b0;
    if ((width % stages) != 0) return 1'b0;
    if (((width / stages) % group) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SW-bit carry-lookahead adder built from GROUP-bit CLA blocks
// with block-level lookahead across the slice; exports slice propagate/generate.
module cla_slice
  import cla_pkg::*;
#(
  parameter int unsigned SW    = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          p,
  output logic          g
);

  localparam int unsigned NG = SW / GROUP;

  logic [SW-1:0] bp, bg, c;
  logic [NG-1:0] gp, gg;
  logic [NG:0]   gc;
  logic          t;

  // Every carry is written as a flat sum of generate-and-propagate products,
  // so no carry depends on a neighbouring carry.
  always_comb begin
    bp = a ^ b;
    bg = a & b;
    gp = '0;
    gg = '0;
    gc = '0;
    c  = '0;
    g  = 1'b0;
    t  = 1'b0;

    for (int unsigned j = 0; j < NG; j++) begin
      gp[j] = &bp[j*GROUP +: GROUP];
      for (int unsigned i = 0; i < GROUP; i++) begin
        t = bg[j*GROUP + i];
        for (int unsigned m = i + 1; m < GROUP; m++) t = t & bp[j*GROUP + m];
        gg[j] = gg[j] | t;
      end
    end

    for (int unsigned j = 0; j <= NG; j++) begin
      t = cin;
      for (int unsigned m = 0; m < j; m++) t = t & gp[m];
      gc[j] = t;
      for (int unsigned i = 0; i < j; i++) begin
        t = gg[i];
        for (int unsigned m = i + 1; m < j; m++) t = t & gp[m];
        gc[j] = gc[j] | t;
      end
    end

    for (int unsigned j = 0; j < NG; j++) begin
      for (int unsigned i = 0; i < GROUP; i++) begin
        t = gc[j];
        for (int unsigned m = 0; m < i; m++) t = t & bp[j*GROUP + m];
        c[j*GROUP + i] = t;
        for (int unsigned q = 0; q < i; q++) begin
          t = bg[j*GROUP + q];
          for (int unsigned m = q + 1; m < i; m++) t = t & bp[j*GROUP + m];
          c[j*GROUP + i] = c[j*GROUP + i] | t;
        end
      end
    end

    for (int unsigned i = 0; i < NG; i++) begin
      t = gg[i];
      for (int unsigned m = i + 1; m < NG; m++) t = t & gp[m];
      g = g | t;
    end

    s    = bp ^ c;
    cout = gc[NG];
    p    = &gp;
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor: one operand slice resolved per
// stage, carry and unresolved operand slices skewed through elastic registers.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned SW = WIDTH / STAGES;

  if (!params_ok(WIDTH, STAGES, GROUP)) begin : g_bad_params
    $error("cla_adder_pipe: illegal WIDTH/STAGES/GROUP combination");
  end

  // w: finished sum slices below the stage boundary, operand A slices above it.
  typedef struct packed {
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             sa;
    logic             sb;
  } pay_t;

  logic [WIDTH-1:0]  b_eff;
  logic [STAGES-1:0] v;
  logic [STAGES:0]   adv;
  logic              rdy;

  assign b_eff = sub ? ~b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy <= 1'b0;
    else        rdy <= 1'b1;
  end

  // Stage k may advance unless it and every stage after it are full and the
  // consumer stalls; written flat to avoid a self-referencing chain.
  always_comb begin
    adv = '0;
    adv[STAGES] = out_ready;
    for (int unsigned k = 0; k < STAGES; k++) begin
      adv[k] = 1'b1;
      for (int unsigned j = k; j < STAGES; j++) adv[k] = adv[k] & v[j];
      adv[k] = !adv[k] | out_ready;
    end
  end

  assign in_ready = adv[0] & rdy;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    pay_t          src, nxt, q;
    logic [SW-1:0] ssum;
    logic          scout, vin, vq, p_unused, g_unused;

    if (k == 0) begin : g_first
      assign src = '{w: a, b: b_eff, c: sub | ci, sa: a[WIDTH-1], sb: b_eff[WIDTH-1]};
      assign vin = in_valid & rdy;
    end else begin : g_next
      assign src = g_st[k-1].q;
      assign vin = v[k-1];
    end

    cla_slice #(.SW(SW), .GROUP(GROUP)) u_slice (
      .a   (src.w[k*SW +: SW]),
      .b   (src.b[k*SW +: SW]),
      .cin (src.c),
      .s   (ssum),
      .cout(scout),
      .p   (p_unused),
      .g   (g_unused)
    );

    always_comb begin
      nxt = src;
      nxt.w[k*SW +: SW] = ssum;
      nxt.c = scout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q  <= '0;
        vq <= 1'b0;
      end else if (adv[k]) begin
        vq <= vin;
        if (vin) q <= nxt;
      end
    end

    assign v[k] = vq;

    if (k == STAGES - 1) begin : g_last
      // Operand B has no remaining slices once the final stage has resolved.
      logic [WIDTH-1:0] b_unused;
      assign b_unused = q.b;
    end
  end

  assign out_valid = v[STAGES-1];
  assign s   = g_st[STAGES-1].q.w;
  assign co  = g_st[STAGES-1].q.c;
  assign ovf = (g_st[STAGES-1].q.sa == g_st[STAGES-1].q.sb) &
               (g_st[STAGES-1].q.w[WIDTH-1] != g_st[STAGES-1].q.sa);

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe (WIDTH=32, STAGES=2): directed vector
// table, backpressure/throughput streams, mid-flight reset and random traffic.
module tb_cla_adder_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned ST = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [W-1:0] a, b, s;

  cla_adder_pipe #(.WIDTH(W), .STAGES(ST), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] es;
    logic        eco;
    logic        eovf;
  } vec_t;

  res_t        expq[$];
  int unsigned pop_cyc[$];
  logic [31:0] pop_s[$];

  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mci, input logic msub);
    res_t        r;
    logic [31:0] be;
    logic [32:0] t;
    be    = msub ? ~mb : mb;
    t     = {1'b0, ma} + {1'b0, be} + {32'd0, (msub ? 1'b1 : mci)};
    r.s   = t[31:0];
    r.co  = t[32];
    r.ovf = (ma[31] == be[31]) && (r.s[31] != ma[31]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: expectations captured at input transfer, compared at output transfer.
  logic        hold_prev = 1'b0;
  logic [31:0] hold_s;
  logic        hold_co, hold_ovf;
  res_t        mr;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!out_valid || s !== hold_s || co !== hold_co || ovf !== hold_ovf) begin
          errors++;
          $display("FAIL hold: valid=%b s=%h co=%b ovf=%b, held s=%h co=%b ovf=%b",
                   out_valid, s, co, ovf, hold_s, hold_co, hold_ovf);
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_s    = s;
      hold_co   = co;
      hold_ovf  = ovf;
      if (in_valid && in_ready) expq.push_back(model(a, b, ci, sub));
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL spurious: result s=%h with no op outstanding", s);
        end else begin
          mr = expq.pop_front();
          if (s !== mr.s || co !== mr.co || ovf !== mr.ovf) begin
            errors++;
            $display("FAIL result: got s=%h co=%b ovf=%b expected s=%h co=%b ovf=%b",
                     s, co, ovf, mr.s, mr.co, mr.ovf);
          end
        end
        pop_cyc.push_back(cyc);
        pop_s.push_back(s);
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                      input logic tsub);
    int unsigned n;
    a = ta; b = tb; ci = tci; sub = tsub;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  vec_t        tv[10];
  int unsigned lat;
  logic        saw_block;
  logic        done;
  int unsigned n;

  initial begin
    tv[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tv[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tv[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tv[3] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    tv[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tv[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};
    tv[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tv[7] = '{32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tv[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tv[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'h0000_1234; b = 32'h0000_4321; ci = 1'b0; sub = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_s", 64'(s), 64'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    for (int i = 0; i < 10; i++) begin
      send(tv[i].a, tv[i].b, tv[i].ci, tv[i].sub);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 10);
      chk($sformatf("latency[%0d]", i), 64'(lat), 64'(ST));
      chk($sformatf("s[%0d]", i), 64'(s), 64'(tv[i].es));
      chk($sformatf("co[%0d]", i), 64'(co), 64'(tv[i].eco));
      chk($sformatf("ovf[%0d]", i), 64'(ovf), 64'(tv[i].eovf));
      @(posedge clk); #1;
    end

    // Stream with the consumer stalled in cycles 3..6.
    pop_cyc.delete(); pop_s.delete(); saw_block = 1'b0;
    fork
      for (int i = 0; i < 8; i++) send(32'(i), 32'(i), 1'b0, 1'b0);
      begin
        for (int c = 0; c < 14; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(negedge clk);
          if (in_valid && !in_ready) saw_block = 1'b1;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (pop_s.size() < 8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_blocks_input", 64'(saw_block), 64'(1));
    chk("stall_result_count", 64'(pop_s.size()), 64'(8));
    for (int i = 0; i < pop_s.size(); i++) chk($sformatf("stall_order[%0d]", i), 64'(pop_s[i]), 64'(2 * i));

    // Same stream, consumer always ready: one result per cycle.
    pop_cyc.delete(); pop_s.delete();
    for (int i = 0; i < 8; i++) send(32'(i), 32'(i), 1'b0, 1'b0);
    n = 0;
    while (pop_s.size() < 8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stream_result_count", 64'(pop_cyc.size()), 64'(8));
    for (int i = 1; i < pop_cyc.size(); i++)
      chk($sformatf("stream_gap[%0d]", i), 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(1));

    // Reset with two ops in flight: neither may appear afterwards.
    out_ready = 1'b0;
    send(32'h0000_0111, 32'h0000_0222, 1'b0, 1'b0);
    send(32'h0000_0333, 32'h0000_0444, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    expq.delete(); pop_s.delete();
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'(0));
    end
    chk("flush_no_results", 64'(pop_s.size()), 64'(0));
    @(posedge clk); #1;

    // Random traffic against the arithmetic model, random consumer stalls.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 3000; k++) begin
          logic [31:0] ra, rb;
          ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
          rb = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom());
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_outstanding", 64'(expq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
